// File: rtl/game_controller_if.sv
// Button inputs and board/cursor outputs of game_controller, bundled with a debug view of the FSM state.
// Buttons carry single-cycle pulses with no ready/ack. A pulse is sampled on exactly one edge; if the block cannot use it that cycle, the pulse is lost, not held.
interface game_controller_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_fire;
    logic [49:0] array_player;
    logic [49:0] array_pc;
    logic [4:0]  select_row;
    logic [4:0]  select_col;
    logic        win;
    logic        lose;
    logic        player_turn;
    logic [2:0]  dbg_state;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_fire,
        input  array_player, array_pc, select_row, select_col, win, lose, player_turn, dbg_state
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_fire,
        output array_player, array_pc, select_row, select_col, win, lose, player_turn, dbg_state
    );
endinterface

// File: rtl/game_controller.sv
// Game-state engine for the 5x5 naval battle: boards, shot cursor, turn order, PC opponent, end of game.
// Optional macro PC_TURN_DELAY_EN: PC waits PC_DELAY cycles in PC_TURN before it picks a target.
module game_controller #(
    parameter int          SHIP_COUNT = 5,
    parameter logic [25:0] PC_DELAY   = 26'd50_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    game_controller_if.slave gc
);

    typedef enum logic [2:0] {
        S_PLACE       = 3'd0,
        S_PC_PLACE    = 3'd1,
        S_PLAYER_TURN = 3'd2,
        S_PC_TURN     = 3'd3,
        S_WIN         = 3'd4,
        S_LOSE        = 3'd5
    } state_t;

    localparam logic [4:0] SHIPS = 5'(SHIP_COUNT);

    // Cell (r,c) starts at bit r*10 + c*2; the shot flag is that bit and the ship flag is the next bit.
    function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
        return ({3'b000, r} << 3) + ({3'b000, r} << 1) + ({3'b000, c} << 1);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [49:0] player_q, player_d;
    logic [49:0] pc_q, pc_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  placed_q, placed_d;
    logic [4:0]  pc_placed_q, pc_placed_d;
    logic [4:0]  pc_hits_q, pc_hits_d;
    logic [4:0]  player_hits_q, player_hits_d;
    logic        win_q, lose_q, turn_q;
    logic [5:0]  cur_idx, cur_ship, rnd_idx, rnd_ship;
    logic        rnd_valid, move_en, pc_ready;

    assign cur_idx   = cell_idx(row_q[2:0], col_q[2:0]);
    assign cur_ship  = {cur_idx[5:1], 1'b1};
    assign rnd_idx   = cell_idx(lfsr_q[2:0], lfsr_q[5:3]);
    assign rnd_ship  = {rnd_idx[5:1], 1'b1};
    assign rnd_valid = (lfsr_q[2:0] < 3'd5) && (lfsr_q[5:3] < 3'd5);

`ifdef PC_TURN_DELAY_EN
    logic [25:0] delay_q, delay_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) delay_q <= '0;
        else      delay_q <= delay_d;
    end
`else
    logic unused_pc_delay;
    assign unused_pc_delay = ^PC_DELAY;
`endif

    always_comb begin
        state_d       = state_q;
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        player_d      = player_q;
        pc_d          = pc_q;
        row_d         = row_q;
        col_d         = col_q;
        placed_d      = placed_q;
        pc_placed_d   = pc_placed_q;
        pc_hits_d     = pc_hits_q;
        player_hits_d = player_hits_q;
`ifdef PC_TURN_DELAY_EN
        delay_d       = delay_q;
        pc_ready      = (delay_q == PC_DELAY);
`else
        pc_ready      = 1'b1;
`endif
        move_en = (state_q == S_PLACE) || (state_q == S_PLAYER_TURN);

        // Fire outranks every move, so a fire pulse blocks moves even when the fire itself is ignored.
        if (move_en && !gc.btn_fire) begin
            if (gc.btn_up)         row_d = (row_q == 5'd0) ? 5'd4 : row_q - 5'd1;
            else if (gc.btn_down)  row_d = (row_q == 5'd4) ? 5'd0 : row_q + 5'd1;
            else if (gc.btn_left)  col_d = (col_q == 5'd0) ? 5'd4 : col_q - 5'd1;
            else if (gc.btn_right) col_d = (col_q == 5'd4) ? 5'd0 : col_q + 5'd1;
        end

        case (state_q)
            S_PLACE: begin
                if (gc.btn_fire && !player_q[cur_ship]) begin
                    player_d[cur_ship] = 1'b1;
                    placed_d           = placed_q + 5'd1;
                    if (placed_d == SHIPS) state_d = S_PC_PLACE;
                end
            end
            S_PC_PLACE: begin
                if (rnd_valid && !pc_q[rnd_ship]) begin
                    pc_d[rnd_ship] = 1'b1;
                    pc_placed_d    = pc_placed_q + 5'd1;
                    if (pc_placed_d == SHIPS) begin
                        row_d   = 5'd0;
                        col_d   = 5'd0;
                        state_d = S_PLAYER_TURN;
                    end
                end
            end
            S_PLAYER_TURN: begin
                if (gc.btn_fire && !pc_q[cur_idx]) begin
                    pc_d[cur_idx] = 1'b1;
                    if (pc_q[cur_ship]) pc_hits_d = pc_hits_q + 5'd1;
                    if (pc_hits_d == SHIPS) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_PC_TURN;
`ifdef PC_TURN_DELAY_EN
                        delay_d = '0;
`endif
                    end
                end
            end
            S_PC_TURN: begin
`ifdef PC_TURN_DELAY_EN
                if (!pc_ready) delay_d = delay_q + 26'd1;
`endif
                if (pc_ready && rnd_valid && !player_q[rnd_idx]) begin
                    player_d[rnd_idx] = 1'b1;
                    if (player_q[rnd_ship]) player_hits_d = player_hits_q + 5'd1;
                    state_d = (player_hits_d == SHIPS) ? S_LOSE : S_PLAYER_TURN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_PLACE;
            lfsr_q        <= LFSR_SEED;
            player_q      <= '0;
            pc_q          <= '0;
            row_q         <= '0;
            col_q         <= '0;
            placed_q      <= '0;
            pc_placed_q   <= '0;
            pc_hits_q     <= '0;
            player_hits_q <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            turn_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            player_q      <= player_d;
            pc_q          <= pc_d;
            row_q         <= row_d;
            col_q         <= col_d;
            placed_q      <= placed_d;
            pc_placed_q   <= pc_placed_d;
            pc_hits_q     <= pc_hits_d;
            player_hits_q <= player_hits_d;
            win_q         <= (state_d == S_WIN);
            lose_q        <= (state_d == S_LOSE);
            turn_q        <= (state_d == S_PLAYER_TURN);
        end
    end

    assign gc.array_player = player_q;
    assign gc.array_pc     = pc_q;
    assign gc.select_row   = row_q;
    assign gc.select_col   = col_q;
    assign gc.win          = win_q;
    assign gc.lose         = lose_q;
    assign gc.player_turn  = turn_q;
    assign gc.dbg_state    = state_q;

endmodule

// File: doc/game_controller.md
# game_controller

Sequential game-state engine for the 5x5-vs-5x5 naval battle screen. Owns both boards, the shot cursor, turn order, the PC opponent and end-of-game detection. Sits directly upstream of the pixel colour generator: its `array_player`, `array_pc`, `select_row`, `select_col`, `win` and `lose` outputs are that stage's inputs, unchanged in encoding.

## Interface

**Parameters**
- `SHIP_COUNT`, default 5: ships per side. Legal range 1..25.
- `PC_DELAY`, default 26'd50_000_000: clock cycles the PC waits before shooting.
- `LFSR_SEED`, default 16'hACE1: reset value of the PC random source. Must be non-zero.

**Ports**
- `clk`  in  1  system clock (single clock domain).
- `rst`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_fire`  in  1 each  debounced single-cycle pulses from the button stage.
- `array_player`  out  50  player board.
- `array_pc`  out  50  PC board.
- `select_row`  out  5  cursor row, binary 0..4.
- `select_col`  out  5  cursor column, binary 0..4.
- `win`  out  1  player sank all PC ships.
- `lose`  out  1  PC sank all player ships.
- `player_turn`  out  1  high in PLAYER_TURN.

## Operation

**Cell encoding.** For row r and column c, idx = r*10 + c*2.
- `[idx]` = shot flag; `[idx+1]` = ship flag.
- 00 water, 01 ship, 10 miss, 11 destroyed.

**Cursor.**
- Up decrements `select_row`; down increments it; left/right do the same for `select_col`.
- Every move wraps 4↔0.
- Cursor moves only in PLACE and PLAYER_TURN.

**Button priority.** If several pulses arrive in one cycle, exactly one is acted on: fire > up > down > left > right.

**LFSR.**
- 16-bit Fibonacci LFSR, taps 16,14,13,11. Shifts every cycle in every state.
- Candidate cell: row = `lfsr[2:0]`, col = `lfsr[5:3]`.
- The candidate is valid only when both values are < 5. An invalid candidate is retried on the next cycle.

**FSM states.**
- **PLACE** (reset state). Fire on a player cell with ship flag 0 sets its ship flag and increments `placed`. Fire on an occupied cell is ignored. When `placed` reaches SHIP_COUNT, go to PC_PLACE.
- **PC_PLACE.** Each cycle, a valid candidate whose PC cell has ship flag 0 gets its ship flag set. When SHIP_COUNT ships are placed, reset the cursor to (0,0) and go to PLAYER_TURN.
- **PLAYER_TURN.**
  - Fire on a PC cell whose shot flag is 1 is ignored and the state is unchanged.
  - Otherwise set the shot flag. If the ship flag is 1, increment `pc_hits`.
  - If `pc_hits` reaches SHIP_COUNT, go to WIN; otherwise go to PC_TURN and clear the delay counter.
- **PC_TURN.**
  - Count up to PC_DELAY (see Configuration). Then take the first valid candidate whose player cell has shot flag 0.
  - Set that cell's shot flag. If its ship flag is 1, increment `player_hits`.
  - If `player_hits` reaches SHIP_COUNT, go to LOSE; otherwise go to PLAYER_TURN.
- **WIN / LOSE.** Terminal. All buttons are ignored; only reset leaves these states.

**Output flags.** `win` is high only in WIN; `lose` is high only in LOSE.

**PC ship flags.** PC ship flags are stored in `array_pc` as-is. Hiding them on screen is the display stage's concern.

**Counters.** `placed`, `pc_hits` and `player_hits` are 5 bits each and never exceed SHIP_COUNT.

## Timing

- **Reset values.** All outputs are 0, state is PLACE, and all counters are 0. The LFSR resets to LFSR_SEED. Reset may be asserted at any time and takes effect immediately, including mid-game.
- **Outputs.** Every output is registered. A button pulse sampled on edge N is visible on the outputs after edge N.
- **Final hit.** The winning or losing hit's board write and the `win`/`lose` assertion become visible on the same edge.
- **PLACE → PLAYER_TURN.** PC_PLACE takes ≥ SHIP_COUNT cycles, plus retry cycles for invalid or occupied candidates.
- **PC_TURN duration.** PC_DELAY cycles, plus ≥1 cycle for the shot, plus retries.
- **Ignored pulses.** A fire or move pulse arriving in PC_PLACE or PC_TURN is dropped, not queued.

## Configuration

- `PC_TURN_DELAY_EN` defined: PC_TURN waits PC_DELAY cycles before sampling candidates, so the player can see the previous shot.
- `PC_TURN_DELAY_EN` undefined: the delay counter is removed and PC_TURN samples on its first cycle. PC_DELAY is then unused.

## Test plan

- **Reset.** Assert `rst`=0 mid-PLAYER_TURN → next cycle shows all outputs 0, and a fire pulse in PLACE sets `array_player[1]` (cell 0,0 gets ship).
- **Placement.** SHIP_COUNT=2: place at (0,0) twice, then (4,4) → `array_player` = bits 1 and 49 set only; two fires were needed beyond the duplicate; state reaches PLAYER_TURN with cursor at (0,0).
- **Cursor.** In PLACE, press left at col 0 → `select_col`=4. Press up at row 0 → `select_row`=4. Press fire and right on the same cycle → only fire acts.
- **Player shot.** In PLAYER_TURN, fire at a PC water cell (2,3) → `array_pc[26]`=1, `array_pc[27]`=0, `player_turn`=0. Fire again at (2,3) on a later player turn → ignored, `player_turn` stays 1.
- **PC turn.** With the macro defined and PC_DELAY=10 → exactly one new player shot flag appears ≥11 cycles after entering PC_TURN, and `player_turn` returns to 1. Without the macro → the shot appears on the first valid cycle.
- **End of game.** SHIP_COUNT=1 with the PC ship known from a fixed seed: fire on it → `win`=1 on the same edge that `array_pc` shows 11. Subsequent buttons change nothing. Symmetric run → `lose`=1.
